// File: rtl/if_fetch.sv
// RV32I fetch: four byte reads over the shared 8-bit port, assembled little-endian into pc/instruction.
// 5-cycle fetch latency (+1 per mem_busy issue cycle); holds the instruction while id_stall; br_en redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  input  logic        br_en,
  input  logic [31:0] br_tgt,
  input  logic        id_stall,
  output logic [31:0] pc_o,
  output logic [31:0] is_o,
  output logic        vld_o
);

  logic [31:0]     pc_q, pc_d;
  logic [2:0]      ni_q, ni_d;
  logic [2:0]      nr_q, nr_d;
  logic            pend_q, pend_d;
  logic            vld_q, vld_d;
  logic [3:0][7:0] buf_q, buf_d;

  // ni_q reaching 4 is what blocks further reads while an instruction is held.
  always_comb begin
    mem_rd = !ni_q[2] && !mem_busy && !br_en && !rst;
    mem_a  = mem_rd ? (pc_q + {29'b0, ni_q}) : 32'h0;
  end

  always_comb begin
    pc_d   = pc_q;
    ni_d   = ni_q;
    nr_d   = nr_q;
    vld_d  = vld_q;
    buf_d  = buf_q;
    pend_d = mem_rd;
    if (br_en) begin
      pc_d   = br_tgt;
      ni_d   = 3'd0;
      nr_d   = 3'd0;
      vld_d  = 1'b0;
      pend_d = 1'b0;
    end else begin
      if (mem_rd) begin
        ni_d = ni_q + 3'd1;
      end
      if (pend_q) begin
        buf_d[nr_q[1:0]] = mem_din;
        nr_d = nr_q + 3'd1;
        if (nr_q == 3'd3) begin
          vld_d = 1'b1;
        end
      end
      if (vld_q && !id_stall) begin
        pc_d  = pc_q + 32'd4;
        ni_d  = 3'd0;
        nr_d  = 3'd0;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ni_q   <= 3'd0;
      nr_q   <= 3'd0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      buf_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ni_q   <= ni_d;
      nr_q   <= nr_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      buf_q  <= buf_d;
    end
  end

  assign pc_o  = pc_q;
  assign vld_o = vld_q;
  assign is_o  = vld_q ? buf_q : 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, stall hold, busy gaps, redirects, address wrap, mid-fetch reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy;
  logic [7:0]  mem_din = 8'hEE;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic        br_en;
  logic [31:0] br_tgt;
  logic        id_stall;
  logic [31:0] pc_o;
  logic [31:0] is_o;
  logic        vld_o;

  int checks = 0;
  int failures = 0;

  if_fetch #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .mem_din(mem_din),
    .mem_a(mem_a), .mem_rd(mem_rd), .br_en(br_en), .br_tgt(br_tgt),
    .id_stall(id_stall), .pc_o(pc_o), .is_o(is_o), .vld_o(vld_o)
  );

  always #5 clk = ~clk;

  // Program bytes at 0x100..0x103 encode addi a0,x0,1; elsewhere byte = addr[7:0] + 0x11.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: mem_byte = 8'h13;
      32'h101: mem_byte = 8'h05;
      32'h102: mem_byte = 8'h10;
      32'h103: mem_byte = 8'h00;
      default: mem_byte = a[7:0] + 8'h11;
    endcase
  endfunction

  always @(posedge clk) mem_din <= mem_rd ? mem_byte(mem_a) : 8'hEE;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    chk({tag, "_rd"}, {31'b0, mem_rd}, 32'd1);
    chk({tag, "_a"}, mem_a, a);
  endtask

  task automatic nord(input string tag);
    chk({tag, "_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({tag, "_a"}, mem_a, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_busy = 1'b0; br_en = 1'b0; br_tgt = 32'h0; id_stall = 1'b0;
    cyc(); cyc();
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_vld", {31'b0, vld_o}, 32'd0);
    chk("rst_is", is_o, 32'h0);
    nord("rst");

    // Fetch at 0x100, no busy
    rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      rd("f1", 32'h100 + i);
      cyc();
    end
    nord("f1_c4");
    chk("f1_c4_vld", {31'b0, vld_o}, 32'd0);
    cyc();
    chk("f1_vld", {31'b0, vld_o}, 32'd1);
    chk("f1_is", is_o, 32'h00100513);
    chk("f1_pc", pc_o, 32'h100);

    // Hold under stall for 10 cycles
    id_stall = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_vld", {31'b0, vld_o}, 32'd1);
      chk("hold_is", is_o, 32'h00100513);
      chk("hold_pc", pc_o, 32'h100);
      nord("hold");
      cyc();
    end
    id_stall = 1'b0; #1;
    chk("acc_vld", {31'b0, vld_o}, 32'd1);
    cyc();

    // Fetch at 0x104 with mem_busy in cycles 1 and 2
    chk("f2_pc", pc_o, 32'h104);
    chk("f2_vld0", {31'b0, vld_o}, 32'd0);
    rd("f2_c0", 32'h104);
    cyc();
    mem_busy = 1'b1; #1;
    nord("f2_c1");
    cyc();
    nord("f2_c2");
    cyc();
    mem_busy = 1'b0; #1;
    rd("f2_c3", 32'h105); cyc();
    rd("f2_c4", 32'h106); cyc();
    rd("f2_c5", 32'h107); cyc();
    nord("f2_c6");
    chk("f2_c6_vld", {31'b0, vld_o}, 32'd0);
    cyc();
    chk("f2_vld", {31'b0, vld_o}, 32'd1);
    chk("f2_is", is_o, 32'h18171615);
    cyc();

    // Fetch at 0x108 redirected in cycle 2
    rd("f3_c0", 32'h108); cyc();
    rd("f3_c1", 32'h109); cyc();
    br_en = 1'b1; br_tgt = 32'h200; #1;
    nord("br");
    cyc();
    br_en = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("f4_pc", pc_o, 32'h200);
      rd("f4", 32'h200 + i);
      cyc();
    end
    chk("f4_c4_vld", {31'b0, vld_o}, 32'd0);
    cyc();
    chk("f4_vld", {31'b0, vld_o}, 32'd1);
    chk("f4_is", is_o, 32'h14131211);

    // Redirect together with accept
    br_en = 1'b1; br_tgt = 32'hFFFF_FFFC; #1;
    nord("bracc");
    cyc();
    br_en = 1'b0; #1;
    chk("bracc_pc", pc_o, 32'hFFFF_FFFC);
    chk("bracc_vld", {31'b0, vld_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd("wrap", 32'hFFFF_FFFC + i);
      cyc();
    end
    cyc();
    chk("wrap_vld", {31'b0, vld_o}, 32'd1);
    chk("wrap_is", is_o, 32'h100F0E0D);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_next_pc", pc_o, 32'h0);
    rd("wrap_next", 32'h0);
    cyc();
    rd("wrap_next1", 32'h1);
    cyc();

    // Reset in the middle of a fetch
    rst = 1'b1; #1;
    nord("mrst_in");
    cyc();
    chk("mrst_pc", pc_o, 32'h100);
    chk("mrst_vld", {31'b0, vld_o}, 32'd0);
    chk("mrst_is", is_o, 32'h0);
    nord("mrst");
    rst = 1'b0; #1;
    rd("mrst_c0", 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RV32I core: produces the `pc`/instruction pair consumed by the decode stage. Fetches each 32-bit instruction as four bytes over the shared 8-bit synchronous memory port, assembles them little-endian, and holds the result under a valid/stall handshake with decode. Accepts single-cycle redirects from the execute stage for branches and jumps.

## Interface
- RESET_PC, 32'h0, fetch address loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_busy  in  1  memory port claimed by load/store this cycle; no fetch read issued
- mem_din  in  8  read data, valid the cycle after a read was issued
- mem_a  out  32  byte address of current read (combinational)
- mem_rd  out  1  read issued this cycle (combinational)
- br_en  in  1  redirect pulse from execute
- br_tgt  in  32  redirect target, sampled when br_en=1
- id_stall  in  1  decode cannot accept this cycle
- pc_o  out  32  address of the instruction being fetched or held
- is_o  out  32  assembled instruction; 32'h0 whenever vld_o=0
- vld_o  out  1  is_o/pc_o hold a complete instruction

## Operation
- Registered state: pc, issue count ni (0..4), receive count nr (0..4), pend (read issued last cycle), byte buffer b0..b3, vld.
- Issue: if ni<4, !mem_busy, !br_en, !rst: mem_rd=1, mem_a=pc+ni (32-bit, wraps), ni<=ni+1. Else mem_rd=0, mem_a=0.
- pend <= mem_rd each cycle.
- Receive: if pend and !br_en: b[nr] <= mem_din, nr<=nr+1; when this makes nr=4, vld<=1.
- Assembly: is_o = vld ? {b3,b2,b1,b0} : 32'h0.
- Hold: while vld=1 and id_stall=1, all state frozen; no reads issued (ni=4).
- Accept: vld=1 and id_stall=0 -> pc<=pc+4 (wraps), ni<=0, nr<=0, vld<=0.
- Redirect (br_en=1): highest priority below rst, overrides stall, busy, accept. pc<=br_tgt, ni<=0, nr<=0, vld<=0, pend<=0; in-flight byte discarded; mem_rd=0 that cycle.
- Reset: pc<=RESET_PC, ni=nr=0, pend=0, vld=0, buffer cleared.
- Reset values of outputs: pc_o=RESET_PC, is_o=0, vld_o=0, mem_rd=0, mem_a=0.
- mem_busy only blocks issue; a byte returning from the previous cycle's read is still captured.
- pc_o = pc at all times.
- No alignment check; pc advances by 4 from any value.

## Timing
- Cycle 0 = first cycle with rst=0 (or first after br_en/accept).
- No busy: reads at cycles 0-3 (pc..pc+3); bytes captured at end of cycles 1-4; vld_o=1 from cycle 5.
- Fetch latency 5 cycles; each mem_busy cycle during issue adds one cycle.
- Accept in cycle k -> vld_o=0 in k+1, next read (pc+4) issued in k+1. Steady-state throughput: one instruction per 6 cycles.
- Redirect in cycle k -> first read of br_tgt in k+1, vld_o=1 at k+6 at the earliest.
- br_en together with accept: redirect wins, the held instruction counts as consumed, pc=br_tgt.
- rst asserted mid-fetch: state cleared at that edge; outputs at reset values from next cycle.

## Test plan
- Reset, RESET_PC=0x100, memory bytes 0x100..0x103 = 13,05,10,00, id_stall=0 -> mem_a 0x100..0x103 cycles 0-3, vld_o=1 cycle 5, is_o=0x00100513, pc_o=0x100; cycle 6 mem_a=0x104.
- id_stall=1 for 10 cycles while vld_o=1 -> is_o/pc_o stable, mem_rd=0 throughout; on release, next fetch starts the following cycle.
- mem_busy=1 in cycles 1 and 2 -> reads at cycles 0,3,4,5, bytes assembled correctly, vld_o at cycle 7.
- br_en with br_tgt=0x200 in cycle 2 of a fetch -> pend byte dropped, mem_rd=0 that cycle, reads 0x200..0x203 from next cycle, is_o from 0x200 only.
- br_en in same cycle as accept -> pc_o=0x200 next cycle, no fetch from old pc+4.
- pc=0xFFFFFFFC fetch and accept -> mem_a sequence FFFFFFFC..FFFFFFFF, then pc_o=0x00000000.
